// File: rtl/tx_serializer.sv
// Parallel-to-serial stage behind the 8b/10b encoder: one-entry holding register
// feeding a shift register, so a word queued mid-transmission streams out with no gap.
module tx_serializer #(
    parameter int WIDTH     = 10,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rest_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_en,
    output logic             word_start,
    output logic             underrun
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             busy;
    logic             underrun_q;

    logic accept;
    logic load_point;
    logic load_word;

    always_comb begin
        accept     = data_valid && !hold_full;
        load_point = !busy || (bit_cnt == LAST_BIT);
        load_word  = load_point && hold_full;
    end

    // Accept and load can never coincide: a load needs hold_full, which blocks accept.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_data <= data_in;
            hold_full <= 1'b1;
        end else if (load_word) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            underrun_q <= 1'b0;
        end else if (load_point) begin
            bit_cnt <= '0;
            if (hold_full) begin
                shift_reg  <= hold_data;
                busy       <= 1'b1;
                underrun_q <= 1'b0;
            end else begin
                // Only flag an underrun when a word has just ended, not while idling.
                shift_reg  <= '0;
                busy       <= 1'b0;
                underrun_q <= busy;
            end
        end else begin
            bit_cnt    <= bit_cnt + CNT_W'(1);
            underrun_q <= 1'b0;
            if (MSB_FIRST) begin
                shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            end else begin
                shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        data_ready = !hold_full;
        ser_en     = busy;
        word_start = busy && (bit_cnt == '0);
        underrun   = underrun_q;
        ser_out    = busy && (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
    end

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: one LSB-first and one MSB-first instance share stimulus;
// a negedge monitor records the LSB-first serial stream for multi-word checks.
module tb_tx_serializer;

    logic       clk = 1'b0;
    logic       rest_n;
    logic [9:0] data_in;
    logic       data_valid;

    logic data_ready0, ser_out0, ser_en0, word_start0, underrun0;
    logic data_ready1, ser_out1, ser_en1, word_start1, underrun1;

    int vectors     = 0;
    int miscompares = 0;

    int   cycle = 0;
    logic bit_q[$];
    logic start_q[$];
    int   cyc_q[$];
    int   und_q[$];

    logic [9:0] stream_words [4];

    always #5 clk = ~clk;

    tx_serializer #(.WIDTH(10), .MSB_FIRST(1'b0)) dut0 (
        .clk        (clk),
        .rest_n     (rest_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready0),
        .ser_out    (ser_out0),
        .ser_en     (ser_en0),
        .word_start (word_start0),
        .underrun   (underrun0)
    );

    tx_serializer #(.WIDTH(10), .MSB_FIRST(1'b1)) dut1 (
        .clk        (clk),
        .rest_n     (rest_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready1),
        .ser_out    (ser_out1),
        .ser_en     (ser_en1),
        .word_start (word_start1),
        .underrun   (underrun1)
    );

    // Mid-cycle capture of every transmitted bit with its cycle number.
    always @(negedge clk) begin
        cycle++;
        if (ser_en0) begin
            bit_q.push_back(ser_out0);
            start_q.push_back(word_start0);
            cyc_q.push_back(cycle);
        end
        if (underrun0) und_q.push_back(cycle);
    end

    task automatic applyStimulus(input logic valid, input logic [9:0] data);
        data_valid = valid;
        data_in    = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ten bits of w, starting with the next edge, then the underrun trailer.
    task automatic streamCheck(input string tag, input logic [9:0] w);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("%s_en%0d", tag, i), 32'(ser_en0), 32'd1);
            checkOutput($sformatf("%s_lsb%0d", tag, i), 32'(ser_out0), 32'(w[i]));
            checkOutput($sformatf("%s_msb%0d", tag, i), 32'(ser_out1), 32'(w[9-i]));
            checkOutput($sformatf("%s_start%0d", tag, i), 32'(word_start0), 32'(i == 0));
            checkOutput($sformatf("%s_start1_%0d", tag, i), 32'(word_start1), 32'(i == 0));
        end
        tick();
        checkOutput({tag, "_end_en"}, 32'(ser_en0), 32'd0);
        checkOutput({tag, "_end_out"}, 32'(ser_out0), 32'd0);
        checkOutput({tag, "_underrun"}, 32'(underrun0), 32'd1);
        checkOutput({tag, "_underrun1"}, 32'(underrun1), 32'd1);
        tick();
        checkOutput({tag, "_underrun_clr"}, 32'(underrun0), 32'd0);
    endtask

    task automatic sendWord(input string tag, input logic [9:0] w);
        logic rdy;
        logic accepted;
        accepted = 1'b0;
        applyStimulus(1'b1, w);
        for (int n = 0; n < 30 && !accepted; n++) begin
            rdy = data_ready0;
            tick();
            accepted = rdy;
        end
        checkOutput({tag, "_accept"}, 32'(accepted), 32'd1);
    endtask

    task automatic checkStream(input string tag, input int bitBase, input int undBase, input int nWords);
        logic [9:0] w;
        int         total;
        total = nWords * 10;
        checkOutput({tag, "_nbits"}, 32'(bit_q.size() - bitBase), 32'(total));
        for (int i = 0; i < total && bitBase + i < bit_q.size(); i++) begin
            w = stream_words[i / 10];
            checkOutput($sformatf("%s_bit%0d", tag, i), 32'(bit_q[bitBase + i]), 32'(w[i % 10]));
            checkOutput($sformatf("%s_start%0d", tag, i), 32'(start_q[bitBase + i]), 32'((i % 10) == 0));
            checkOutput($sformatf("%s_gap%0d", tag, i), 32'(cyc_q[bitBase + i] - cyc_q[bitBase]), 32'(i));
        end
        checkOutput({tag, "_nunderrun"}, 32'(und_q.size() - undBase), 32'd1);
        if (und_q.size() > undBase && bit_q.size() >= bitBase + total)
            checkOutput({tag, "_underrun_pos"}, 32'(und_q[undBase]), 32'(cyc_q[bitBase + total - 1] + 1));
    endtask

    initial begin
        logic [9:0] wa;
        logic [9:0] wb;
        int         bitBase;
        int         undBase;

        // Reset with random inputs: everything quiet except data_ready.
        rest_n = 1'b0;
        applyStimulus(1'b0, 10'h000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 10'($urandom));
            tick();
            checkOutput($sformatf("rst_ready%0d", i), 32'(data_ready0), 32'd1);
            checkOutput($sformatf("rst_out%0d", i), 32'(ser_out0), 32'd0);
            checkOutput($sformatf("rst_en%0d", i), 32'(ser_en0), 32'd0);
            checkOutput($sformatf("rst_start%0d", i), 32'(word_start0), 32'd0);
            checkOutput($sformatf("rst_underrun%0d", i), 32'(underrun0), 32'd0);
            checkOutput($sformatf("rst_ready1_%0d", i), 32'(data_ready1), 32'd1);
            checkOutput($sformatf("rst_en1_%0d", i), 32'(ser_en1), 32'd0);
        end
        applyStimulus(1'b0, 10'h3FF);
        rest_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("idle_en%0d", i), 32'(ser_en0), 32'd0);
            checkOutput($sformatf("idle_ready%0d", i), 32'(data_ready0), 32'd1);
            checkOutput($sformatf("idle_underrun%0d", i), 32'(underrun0), 32'd0);
        end

        // Single word, both bit orders.
        applyStimulus(1'b1, 10'b0011111010);
        tick();
        applyStimulus(1'b0, 10'h000);
        checkOutput("single_ready_low", 32'(data_ready0), 32'd0);
        checkOutput("single_not_yet", 32'(ser_en0), 32'd0);
        streamCheck("single", 10'b0011111010);

        // Back-to-back with data_valid held high.
        $display("[TB] back-to-back stream");
        bitBase = bit_q.size();
        undBase = und_q.size();
        stream_words[0] = 10'h17C;
        stream_words[1] = 10'h283;
        stream_words[2] = 10'h0F5;
        for (int i = 0; i < 3; i++) sendWord($sformatf("b2b_w%0d", i), stream_words[i]);
        applyStimulus(1'b0, 10'h000);
        repeat (25) tick();
        checkStream("b2b", bitBase, undBase, 3);

        // Backpressure: distinct words queued as fast as data_ready allows.
        $display("[TB] backpressure stream");
        bitBase = bit_q.size();
        undBase = und_q.size();
        stream_words[0] = 10'h2AA;
        stream_words[1] = 10'h155;
        stream_words[2] = 10'h3C3;
        stream_words[3] = 10'h0FF;
        for (int i = 0; i < 4; i++) sendWord($sformatf("bp_w%0d", i), stream_words[i]);
        applyStimulus(1'b0, 10'h000);
        repeat (25) tick();
        checkStream("bp", bitBase, undBase, 4);

        // Late arrival: second word accepted on the edge that ends bit 9.
        wa = 10'h1E3;
        wb = 10'h2D4;
        applyStimulus(1'b1, wa);
        tick();
        applyStimulus(1'b0, 10'h000);
        repeat (10) tick();
        checkOutput("late_a_bit9_en", 32'(ser_en0), 32'd1);
        checkOutput("late_a_bit9", 32'(ser_out0), 32'(wa[9]));
        applyStimulus(1'b1, wb);
        tick();
        applyStimulus(1'b0, 10'h000);
        checkOutput("late_gap_en", 32'(ser_en0), 32'd0);
        checkOutput("late_gap_underrun", 32'(underrun0), 32'd1);
        checkOutput("late_gap_ready", 32'(data_ready0), 32'd0);
        streamCheck("late_b", wb);

        // Reset during bit 4 with another word held.
        wa = 10'h3A5;
        applyStimulus(1'b1, wa);
        tick();
        applyStimulus(1'b1, 10'h05A);
        repeat (5) tick();
        checkOutput("mid_bit4_en", 32'(ser_en0), 32'd1);
        checkOutput("mid_bit4", 32'(ser_out0), 32'(wa[4]));
        checkOutput("mid_held", 32'(data_ready0), 32'd0);
        #2;
        rest_n = 1'b0;
        applyStimulus(1'b0, 10'h000);
        #1;
        checkOutput("mid_rst_en", 32'(ser_en0), 32'd0);
        checkOutput("mid_rst_out", 32'(ser_out0), 32'd0);
        checkOutput("mid_rst_start", 32'(word_start0), 32'd0);
        checkOutput("mid_rst_underrun", 32'(underrun0), 32'd0);
        checkOutput("mid_rst_ready", 32'(data_ready0), 32'd1);
        checkOutput("mid_rst_en1", 32'(ser_en1), 32'd0);
        repeat (2) tick();
        checkOutput("mid_rst_hold_en", 32'(ser_en0), 32'd0);
        rest_n = 1'b1;
        wb = 10'h2C9;
        applyStimulus(1'b1, wb);
        tick();
        applyStimulus(1'b0, 10'h000);
        checkOutput("recover_not_yet", 32'(ser_en0), 32'd0);
        streamCheck("recover", wb);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("recover_quiet%0d", i), 32'(ser_en0), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
